spectrum_peak_reader: RTL and testbench

- Consumer at the output end of the FFT path; accepts one 32-bit spectrum word per bin over a valid/ready handshake.
- Per bin it computes an L1 magnitude. Across one frame it tracks the peak bin and accumulates total energy.
- At the end of each frame it presents one result record through a second valid/ready handshake to the control/display logic.

---
 rtl/fft_pkg.sv | 38 +++
 rtl/spectrum_mag_l1.sv | 30 +++
 rtl/spectrum_peak_reader.sv | 127 ++++++++++++
 tb/tb_spectrum_peak_reader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output path: default widths, the derived
// width helpers and the spectrum word field extractors.
package fft_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_e;

    // Bin index width for a frame of n bins.
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    // L1 magnitude width: |re|+|im| peaks at exactly 2^dw.
    function automatic int mag_w(input int dw);
        return dw + 1;
    endfunction

    // Frame energy width: n bins of at most 2^dw each.
    function automatic int sum_w(input int n, input int dw);
        return dw + 1 + $clog2(n);
    endfunction

    // Real field (low dw bits), sign-extended. Word is zero-extended to 64
    // bits by the caller, so component widths up to 32 are supported.
    function automatic logic signed [63:0] spec_re(input logic [63:0] w, input int dw);
        return $signed(w << (64 - dw)) >>> (64 - dw);
    endfunction

    // Imaginary field (bits [2*dw-1:dw]), sign-extended.
    function automatic logic signed [63:0] spec_im(input logic [63:0] w, input int dw);
        return $signed(w << (64 - 2 * dw)) >>> (64 - dw);
    endfunction

endpackage

// File: rtl/spectrum_mag_l1.sv
// Combinational L1 magnitude |re| + |im| of one spectrum word. The most
// negative component maps to exactly 2^(DATA_W-1), so no saturation is
// needed and the sum always fits in DATA_W+1 bits.
module spectrum_mag_l1
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    localparam int MAG_W = mag_w(DATA_W)
) (
    input  logic [2*DATA_W-1:0] word_i,
    output logic [MAG_W-1:0]    mag_o
);

    logic [63:0]        w64;
    logic signed [63:0] re, im;
    logic [MAG_W-1:0]   abs_re, abs_im;

    assign w64 = 64'(word_i);
    assign re  = spec_re(w64, DATA_W);
    assign im  = spec_im(w64, DATA_W);

    // Absolute values computed wide, then narrowed; the magnitude of a
    // DATA_W-bit component always fits in MAG_W bits.
    always_comb begin
        abs_re = (re < 0) ? MAG_W'(-re) : MAG_W'(re);
        abs_im = (im < 0) ? MAG_W'(-im) : MAG_W'(im);
        mag_o  = abs_re + abs_im;
    end

endmodule

// File: rtl/spectrum_peak_reader.sv
// Frame-level consumer of FFT bins: finds the peak-magnitude bin and the
// total L1 energy of each frame, then offers one result record downstream.
// One idle cycle (the REPORT handshake) separates consecutive frames.
module spectrum_peak_reader
    import fft_pkg::*;
#(
    parameter int N_BINS = 64,
    parameter int DATA_W = DATA_W_DEF,
    localparam int IDX_W = idx_w(N_BINS),
    localparam int MAG_W = mag_w(DATA_W),
    localparam int SUM_W = sum_w(N_BINS, DATA_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*DATA_W-1:0] spectrum,
    input  logic                spectrum_valid,
    input  logic                spectrum_last,
    output logic                spectrum_ready,
    output logic                peak_valid,
    input  logic                peak_ready,
    output logic [IDX_W-1:0]    peak_bin,
    output logic [MAG_W-1:0]    peak_mag,
    output logic [SUM_W-1:0]    frame_energy,
    output logic                frame_err
);

    state_e           state_q, state_d;
    logic             live_q;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [MAG_W-1:0] best_mag_q, best_mag_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [SUM_W-1:0] energy_q, energy_d;

    logic [IDX_W-1:0] peak_bin_q;
    logic [MAG_W-1:0] peak_mag_q;
    logic [SUM_W-1:0] frame_energy_q;
    logic             frame_err_q;

    logic [MAG_W-1:0] mag;
    logic             accept, first_bin, last_bin, frame_end;

    spectrum_mag_l1 #(.DATA_W(DATA_W)) u_mag (
        .word_i (spectrum),
        .mag_o  (mag)
    );

    assign accept    = spectrum_valid && spectrum_ready;
    assign first_bin = (cnt_q == '0);
    assign last_bin  = (cnt_q == IDX_W'(N_BINS - 1));
    // A frame closes on an explicit last or on the N_BINS-th word.
    assign frame_end = accept && (spectrum_last || last_bin);

    // Handshake FSM: collect bins, then hold the record until taken.
    always_comb begin
        state_d        = state_q;
        spectrum_ready = 1'b0;
        peak_valid     = 1'b0;
        case (state_q)
            COLLECT: begin
                spectrum_ready = live_q;
                if (frame_end) state_d = REPORT;
            end
            REPORT: begin
                peak_valid = 1'b1;
                if (peak_ready) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // Running peak / energy / bin count; bin 0 restarts the accumulators,
    // ties keep the earlier index because only a strict increase replaces.
    always_comb begin
        cnt_d      = cnt_q;
        best_mag_d = best_mag_q;
        best_idx_d = best_idx_q;
        energy_d   = energy_q;
        if (accept) begin
            if (first_bin || (mag > best_mag_q)) begin
                best_mag_d = mag;
                best_idx_d = cnt_q;
            end
            energy_d = first_bin ? SUM_W'(mag) : energy_q + SUM_W'(mag);
            cnt_d    = frame_end ? '0 : cnt_q + 1'b1;
        end
    end

    // State, accumulators and the ready-after-reset flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            live_q     <= 1'b0;
            cnt_q      <= '0;
            best_mag_q <= '0;
            best_idx_q <= '0;
            energy_q   <= '0;
        end else begin
            state_q    <= state_d;
            live_q     <= 1'b1;
            cnt_q      <= cnt_d;
            best_mag_q <= best_mag_d;
            best_idx_q <= best_idx_d;
            energy_q   <= energy_d;
        end
    end

    // Result record, captured at frame end including the closing word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_bin_q     <= '0;
            peak_mag_q     <= '0;
            frame_energy_q <= '0;
            frame_err_q    <= 1'b0;
        end else if (frame_end) begin
            peak_bin_q     <= best_idx_d;
            peak_mag_q     <= best_mag_d;
            frame_energy_q <= energy_d;
            frame_err_q    <= (spectrum_last != last_bin);
        end
    end

    assign peak_bin     = peak_bin_q;
    assign peak_mag     = peak_mag_q;
    assign frame_energy = frame_energy_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spectrum_peak_reader.sv
module tb_spectrum_peak_reader;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int IW = 3;
    localparam int MW = 17;
    localparam int SW = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2*DW-1:0] spectrum;
    logic            spectrum_valid, spectrum_last, spectrum_ready;
    logic            peak_valid, peak_ready;
    logic [IW-1:0]   peak_bin;
    logic [MW-1:0]   peak_mag;
    logic [SW-1:0]   frame_energy;
    logic            frame_err;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        int bin;
        int mag;
        int energy;
        int err;
    } res_t;

    always #5 clk = ~clk;

    spectrum_peak_reader #(.N_BINS(N), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spectrum       (spectrum),
        .spectrum_valid (spectrum_valid),
        .spectrum_last  (spectrum_last),
        .spectrum_ready (spectrum_ready),
        .peak_valid     (peak_valid),
        .peak_ready     (peak_ready),
        .peak_bin       (peak_bin),
        .peak_mag       (peak_mag),
        .frame_energy   (frame_energy),
        .frame_err      (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkw(input int im, input int re);
        logic [15:0] a, b;
        a = im[15:0];
        b = re[15:0];
        return {a, b};
    endfunction

    function automatic int l1(input logic [31:0] w);
        int re, im;
        logic signed [15:0] r, i;
        r  = w[15:0];
        i  = w[31:16];
        re = r;
        im = i;
        return (re < 0 ? -re : re) + (im < 0 ? -im : im);
    endfunction

    // Reference: peak is the first bin holding the maximum, energy the sum;
    // the frame is in error unless it is exactly N long and closed by last.
    function automatic res_t model(input logic [31:0] ws[$], input bit last_on_final);
        res_t r;
        r.bin = 0; r.mag = -1; r.energy = 0;
        foreach (ws[k]) begin
            if (l1(ws[k]) > r.mag) begin
                r.mag = l1(ws[k]);
                r.bin = k;
            end
            r.energy += l1(ws[k]);
        end
        r.err = (ws.size() == N && last_on_final) ? 0 : 1;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [31:0] w, input bit last);
        int budget = 50;
        spectrum       = w;
        spectrum_valid = 1'b1;
        spectrum_last  = last;
        while (!spectrum_ready && budget > 0) begin
            @(posedge clk); @(negedge clk);
            budget--;
        end
        if (budget == 0) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); @(negedge clk);
        spectrum_valid = 1'b0;
        spectrum_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] ws[$], input bit last_on_final, input bit gaps);
        foreach (ws[k]) begin
            if (gaps && k > 0) repeat ($urandom_range(0, 2)) begin
                @(posedge clk); @(negedge clk);
            end
            send_word(ws[k], last_on_final && (k == ws.size() - 1));
            if (k < ws.size() - 1) check("no_early_valid", 32'(peak_valid), 32'd0);
        end
    endtask

    task automatic check_record(input string tag, input res_t r);
        check({tag, "_valid"},  32'(peak_valid),   32'd1);
        check({tag, "_bin"},    32'(peak_bin),     32'(r.bin));
        check({tag, "_mag"},    32'(peak_mag),     32'(r.mag));
        check({tag, "_energy"}, 32'(frame_energy), 32'(r.energy));
        check({tag, "_err"},    32'(frame_err),    32'(r.err));
    endtask

    // Hold the record for 'hold' cycles (optionally with a word waiting
    // upstream), then take it and verify the block is ready again.
    task automatic drain(input string tag, input res_t r, input int hold, input logic [31:0] pend);
        check_record(tag, r);
        if (hold > 0) begin
            spectrum       = pend;
            spectrum_valid = 1'b1;
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); @(negedge clk);
            check({tag, "_stall_rdy"}, 32'(spectrum_ready), 32'd0);
            check_record({tag, "_hold"}, r);
        end
        peak_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        peak_ready = 1'b0;
        check({tag, "_taken"},  32'(peak_valid),     32'd0);
        check({tag, "_rdy"},    32'(spectrum_ready), 32'd1);
        spectrum_valid = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_rdy"},    32'(spectrum_ready), 32'd0);
        check({tag, "_valid"},  32'(peak_valid),     32'd0);
        check({tag, "_bin"},    32'(peak_bin),       32'd0);
        check({tag, "_mag"},    32'(peak_mag),       32'd0);
        check({tag, "_energy"}, 32'(frame_energy),   32'd0);
        check({tag, "_err"},    32'(frame_err),      32'd0);
    endtask

    initial begin
        logic [31:0] ws[$];
        res_t r;
        int len;
        bit lst;

        rst_n = 1'b0; spectrum = '0; spectrum_valid = 1'b0;
        spectrum_last = 1'b0; peak_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        #1 check("rdy_before_edge", 32'(spectrum_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        check("rdy_after_edge", 32'(spectrum_ready), 32'd1);

        // Single nonzero bin.
        ws = {};
        for (int k = 0; k < N; k++) ws.push_back(k == 5 ? mkw(-3, 4) : 32'd0);
        send_frame(ws, 1'b1, 1'b0);
        r = model(ws, 1'b1);
        check("single_mag_const", 32'(peak_mag), 32'd7);
        drain("single", r, 0, '0);

        // Tie keeps the lower index.
        ws = {};
        for (int k = 0; k < N; k++) ws.push_back((k == 2 || k == 6) ? mkw(0, 100) : mkw(0, 1));
        send_frame(ws, 1'b1, 1'b0);
        r = model(ws, 1'b1);
        check("tie_bin_const", 32'(peak_bin), 32'd2);
        check("tie_energy_const", 32'(frame_energy), 32'd206);
        drain("tie", r, 0, '0);

        // Most negative components everywhere.
        ws = {};
        for (int k = 0; k < N; k++) ws.push_back(32'h8000_8000);
        send_frame(ws, 1'b1, 1'b0);
        r = model(ws, 1'b1);
        check("ext_mag_const", 32'(peak_mag), 32'd65536);
        check("ext_energy_const", 32'(frame_energy), 32'd524288);
        drain("ext", r, 0, '0);

        // Short frame, then a frame whose peak is bin 0.
        ws = {mkw(1, 2), mkw(5, 5), mkw(-2, 0), mkw(3, -9)};
        send_frame(ws, 1'b1, 1'b0);
        r = model(ws, 1'b1);
        check("short_err_const", 32'(frame_err), 32'd1);
        drain("short", r, 0, '0);
        ws = {};
        for (int k = 0; k < N; k++) ws.push_back(k == 0 ? mkw(500, -500) : mkw(k, k));
        send_frame(ws, 1'b1, 1'b0);
        drain("after_short", model(ws, 1'b1), 0, '0);

        // Full-length frame without last flags an error.
        ws = {};
        for (int k = 0; k < N; k++) ws.push_back(mkw(k, -k));
        send_frame(ws, 1'b0, 1'b0);
        drain("nolast", model(ws, 1'b0), 0, '0);

        // Backpressure with a word waiting upstream.
        ws = {};
        for (int k = 0; k < N; k++) ws.push_back(mkw(-k * 7, 40 - k));
        send_frame(ws, 1'b1, 1'b0);
        drain("bp", model(ws, 1'b1), 10, mkw(9, 9));
        ws = {};
        for (int k = 0; k < N; k++) ws.push_back(k == 0 ? mkw(9, 9) : mkw(0, k));
        send_frame(ws, 1'b1, 1'b0);
        drain("after_bp", model(ws, 1'b1), 0, '0);

        // Reset part-way through a frame.
        for (int k = 0; k < 3; k++) send_word(mkw(1000, 1000), 1'b0);
        rst_n = 1'b0;
        #1 check_cleared("midframe_rst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        ws = {};
        for (int k = 0; k < N; k++) ws.push_back(mkw(k, 2));
        send_frame(ws, 1'b1, 1'b0);
        drain("post_rst", model(ws, 1'b1), 0, '0);

        // Reset while a record is pending.
        send_frame(ws, 1'b1, 1'b0);
        check("pre_rst_valid", 32'(peak_valid), 32'd1);
        rst_n = 1'b0;
        #1 check_cleared("report_rst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); @(negedge clk);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N) : N;
            lst = (len < N) ? 1'b1 : 1'($urandom_range(0, 5) != 0);
            ws = {};
            for (int k = 0; k < len; k++) begin
                case ($urandom_range(0, 3))
                    0:       ws.push_back(32'h8000_8000);
                    1:       ws.push_back(mkw($urandom_range(0, 3), $urandom_range(0, 3)));
                    default: ws.push_back($urandom);
                endcase
            end
            send_frame(ws, lst, 1'b1);
            drain("rand", model(ws, lst), $urandom_range(0, 3), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
